execute_cycle: RTL and testbench

EXECUTE_CYCLE -- requirements
Module: execute_cycle

---
 rtl/execute_cycle_if.sv | 29 ++
 rtl/execute_cycle.sv | 154 +++++++++++++++
 tb/tb_execute_cycle.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/execute_cycle_if.sv
// Execute-stage signal bundle: ID/EX controls and operands in, EX/MEM register and branch/stall results out.
interface execute_cycle_if;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardA_E, ForwardB_E, ResultW,
    input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );

  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardA_E, ForwardB_E, ResultW,
    output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );
endinterface

// File: rtl/execute_cycle.sv
// RISC-V style execute stage: forwarding, ALU, branch resolution, 32-cycle shift-add multiplier
// and the EX/MEM pipeline register.
module execute_cycle (
  input  logic            clk,
  input  logic            rst,
  execute_cycle_if.slave  ex
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q, mplier_q, prod_q;

  logic        reg_write_q, mem_write_q, result_src_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_plus4_q, write_data_q, alu_result_q;

  logic        reg_write_d, mem_write_d, result_src_d;
  logic [4:0]  rd_d;
  logic [31:0] pc_plus4_d, write_data_d, alu_result_d;

  logic [31:0] src_a_s, fwd_b_s, src_b_s, alu_s;
  logic        zero_s, stall_s;

  // Forwarding muxes; select 11 falls back to the register-file operand.
  always_comb begin
    case (ex.ForwardA_E)
      2'b01:   src_a_s = ex.ResultW;
      2'b10:   src_a_s = alu_result_q;
      default: src_a_s = ex.RD1_E;
    endcase
    case (ex.ForwardB_E)
      2'b01:   fwd_b_s = ex.ResultW;
      2'b10:   fwd_b_s = alu_result_q;
      default: fwd_b_s = ex.RD2_E;
    endcase
    if (ex.ALUSrcE) begin
      src_b_s = ex.Imm_Ext_E;
    end else begin
      src_b_s = fwd_b_s;
    end
  end

  // ALU; unlisted operation codes produce zero.
  always_comb begin
    case (ex.ALUControlE)
      3'b000:  alu_s = src_a_s + src_b_s;
      3'b001:  alu_s = src_a_s - src_b_s;
      3'b010:  alu_s = src_a_s & src_b_s;
      3'b011:  alu_s = src_a_s | src_b_s;
      3'b101:  alu_s = ($signed(src_a_s) < $signed(src_b_s)) ? 32'd1 : 32'd0;
      default: alu_s = 32'd0;
    endcase
  end

  assign zero_s       = (alu_s == 32'd0);
  assign stall_s      = ((state_q == IDLE) && ex.MulE) || (state_q == MUL);
  assign ex.PCSrcE    = ex.BranchE & zero_s & ~ex.MulE;
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;
  assign ex.StallE    = stall_s;

  // EX/MEM next value: bubble while stalled, product in DONE, ALU result otherwise.
  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 1'b0;
    rd_d         = 5'd0;
    pc_plus4_d   = 32'd0;
    write_data_d = 32'd0;
    alu_result_d = 32'd0;
    if (stall_s) begin
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
    end else if (state_q == DONE) begin
      reg_write_d  = ex.RegWriteE;
      mem_write_d  = ex.MemWriteE;
      result_src_d = ex.ResultSrcE;
      rd_d         = ex.RD_E;
      pc_plus4_d   = ex.PCPlus4E;
      alu_result_d = prod_q;
    end else begin
      reg_write_d  = ex.RegWriteE;
      mem_write_d  = ex.MemWriteE;
      result_src_d = ex.ResultSrcE;
      rd_d         = ex.RD_E;
      pc_plus4_d   = ex.PCPlus4E;
      write_data_d = fwd_b_s;
      alu_result_d = alu_s;
    end
  end

  // Multiply FSM, multiplier datapath and EX/MEM register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      mcand_q      <= 32'd0;
      mplier_q     <= 32'd0;
      prod_q       <= 32'd0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= 5'd0;
      pc_plus4_q   <= 32'd0;
      write_data_q <= 32'd0;
      alu_result_q <= 32'd0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      write_data_q <= write_data_d;
      alu_result_q <= alu_result_d;
      case (state_q)
        IDLE: begin
          if (ex.MulE) begin
            // Operands are latched here so later forwarding changes cannot disturb the product.
            mcand_q  <= src_a_s;
            mplier_q <= fwd_b_s;
            prod_q   <= 32'd0;
            cnt_q    <= 5'd0;
            state_q  <= MUL;
          end else begin
            state_q  <= IDLE;
          end
        end
        MUL: begin
          prod_q   <= prod_q + (mplier_q[0] ? mcand_q : 32'd0);
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
          end else begin
            state_q <= MUL;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex.RegWriteM   = reg_write_q;
  assign ex.MemWriteM   = mem_write_q;
  assign ex.ResultSrcM  = result_src_q;
  assign ex.RD_M        = rd_q;
  assign ex.PCPlus4M    = pc_plus4_q;
  assign ex.WriteDataM  = write_data_q;
  assign ex.ALU_ResultM = alu_result_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: expected EX/MEM contents are queued as each cycle is driven.
module tb_execute_cycle;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_cycle_if ex_if ();
  execute_cycle dut (.clk(clk), .rst(rst), .ex(ex_if));

  typedef struct packed {
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] pc4, wd, alu;
  } exm_t;

  exm_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          m_state = 0;
  int          m_cnt = 0;
  int          stall_cnt = 0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_alu = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
    case (sel)
      2'b01:   return ex_if.ResultW;
      2'b10:   return m_alu;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic alusrc, input logic [1:0] fa,
                        input logic [1:0] fb, input logic br, input logic mul, input logic [4:0] rd);
    ex_if.ALUControlE = op;
    ex_if.RD1_E       = a;
    ex_if.RD2_E       = b;
    ex_if.Imm_Ext_E   = imm;
    ex_if.ALUSrcE     = alusrc;
    ex_if.ForwardA_E  = fa;
    ex_if.ForwardB_E  = fb;
    ex_if.BranchE     = br;
    ex_if.MulE        = mul;
    ex_if.RD_E        = rd;
    ex_if.RegWriteE   = 1'b1;
    ex_if.MemWriteE   = rd[0];
    ex_if.ResultSrcE  = rd[1];
    ex_if.PCE         = 32'h0000_1000 + {25'd0, rd, 2'b00};
    ex_if.PCPlus4E    = ex_if.PCE + 32'd4;
  endtask

  // One clock: check combinational outputs, queue the expected EX/MEM load, then compare it.
  task automatic step();
    exm_t        e;
    logic [31:0] fa, fb, sb, res;
    logic        exp_stall;
    #1;
    fa  = fwd(ex_if.ForwardA_E, ex_if.RD1_E);
    fb  = fwd(ex_if.ForwardB_E, ex_if.RD2_E);
    sb  = ex_if.ALUSrcE ? ex_if.Imm_Ext_E : fb;
    res = ref_alu(ex_if.ALUControlE, fa, sb);
    exp_stall = ((m_state == 0) && ex_if.MulE) || (m_state == 1);
    check_val("stall", {31'd0, ex_if.StallE}, {31'd0, exp_stall});
    check_val("pcsrc", {31'd0, ex_if.PCSrcE},
              {31'd0, ex_if.BranchE & (res == 32'd0) & ~ex_if.MulE});
    check_val("pctarget", ex_if.PCTargetE, ex_if.PCE + ex_if.Imm_Ext_E);
    if (ex_if.StallE === 1'b1) stall_cnt++;
    e = '0;
    if (!rst) begin
      m_state = 0; m_cnt = 0; m_a = 32'd0; m_b = 32'd0;
    end else if (exp_stall) begin
      if (m_state == 0) begin
        m_a = fa; m_b = fb; m_cnt = 0; m_state = 1;
      end else begin
        m_cnt++;
        if (m_cnt == 32) m_state = 2;
      end
    end else if (m_state == 2) begin
      e.rw = ex_if.RegWriteE; e.mw = ex_if.MemWriteE; e.rs = ex_if.ResultSrcE;
      e.rd = ex_if.RD_E; e.pc4 = ex_if.PCPlus4E; e.alu = m_a * m_b;
      m_state = 0;
    end else begin
      e.rw = ex_if.RegWriteE; e.mw = ex_if.MemWriteE; e.rs = ex_if.ResultSrcE;
      e.rd = ex_if.RD_E; e.pc4 = ex_if.PCPlus4E; e.wd = fb; e.alu = res;
    end
    sb_q.push_back(e);
    m_alu = e.alu;
    @(posedge clk);
    #1;
    check_val("sb_depth", sb_q.size(), 32'd1);
    e = sb_q.pop_front();
    check_val("RegWriteM", {31'd0, ex_if.RegWriteM}, {31'd0, e.rw});
    check_val("MemWriteM", {31'd0, ex_if.MemWriteM}, {31'd0, e.mw});
    check_val("ResultSrcM", {31'd0, ex_if.ResultSrcM}, {31'd0, e.rs});
    check_val("RD_M", {27'd0, ex_if.RD_M}, {27'd0, e.rd});
    check_val("PCPlus4M", ex_if.PCPlus4M, e.pc4);
    check_val("WriteDataM", ex_if.WriteDataM, e.wd);
    check_val("ALU_ResultM", ex_if.ALU_ResultM, e.alu);
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input string tag);
    set_op(3'b110, a, b, 32'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, rd);
    stall_cnt = 0;
    repeat (34) step();
    check_val({tag, "_prod"}, ex_if.ALU_ResultM, exp);
    check_val({tag, "_stall_len"}, stall_cnt, 32'd33);
  endtask

  logic [2:0]  ops [8] = '{3'b010, 3'b011, 3'b101, 3'b101, 3'b111, 3'b100, 3'b001, 3'b110};
  logic [31:0] opa [8] = '{32'hF0F0_1234, 32'h0F00_0001, 32'hFFFF_FFFF, 32'd1,
                           32'd9, 32'd9, 32'd0, 32'd5};
  logic [31:0] opb [8] = '{32'h0FF0_FFFF, 32'h00F0_0010, 32'd1, 32'hFFFF_FFFF,
                           32'd3, 32'd3, 32'd1, 32'd5};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ex_if.ResultW = 32'd0;
    set_op(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_alu", ex_if.ALU_ResultM, 32'd0);
    check_val("rst_regwrite", {31'd0, ex_if.RegWriteM}, 32'd0);
    check_val("rst_stall", {31'd0, ex_if.StallE}, 32'd0);
    rst = 1'b1;

    // ADD 5 + 7.
    set_op(3'b000, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd3);
    step();
    check_val("add_res", ex_if.ALU_ResultM, 32'd12);
    check_val("add_rw", {31'd0, ex_if.RegWriteM}, 32'd1);

    // Branch on equal via SUB, taken and not taken.
    set_op(3'b001, 32'h10, 32'h10, 32'h40, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd4);
    #1 check_val("beq_taken", {31'd0, ex_if.PCSrcE}, 32'd1);
    check_val("beq_target", ex_if.PCTargetE, 32'h0000_1010 + 32'h40);
    step();
    ex_if.RD2_E = 32'h11;
    #1 check_val("beq_not_taken", {31'd0, ex_if.PCSrcE}, 32'd0);
    step();

    // Forwarding from writeback, then from EX/MEM.
    ex_if.ResultW = 32'h100;
    set_op(3'b000, 32'd0, 32'd0, 32'd4, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 5'd6);
    step();
    check_val("fwdA_wb", ex_if.ALU_ResultM, 32'h104);
    set_op(3'b000, 32'd1, 32'd55, 32'd0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 5'd7);
    step();
    check_val("fwdB_mem", ex_if.WriteDataM, 32'h104);

    for (int i = 0; i < 8; i++) begin
      set_op(ops[i], opa[i], opb[i], 32'd8, 1'b0, 2'b11, 2'b11, i[0], 1'b0, 5'(i + 8));
      step();
    end

    // Multiply -1 * 3 with SrcA forwarded from writeback, ResultW disturbed mid-multiply.
    ex_if.ResultW = 32'hFFFF_FFFF;
    set_op(3'b110, 32'd0, 32'd3, 32'd0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 5'd9);
    stall_cnt = 0;
    step();
    for (int i = 0; i < 33; i++) begin
      ex_if.ResultW = 32'h1234_0000 + 32'(i);
      step();
    end
    check_val("mul_neg_prod", ex_if.ALU_ResultM, 32'hFFFF_FFFD);
    check_val("mul_neg_rw", {31'd0, ex_if.RegWriteM}, 32'd1);
    check_val("mul_neg_stall_len", stall_cnt, 32'd33);

    // Back-to-back multiplies.
    run_mul(32'd6, 32'd7, 5'd10, 32'd42, "mul_6x7");
    run_mul(32'h0001_0000, 32'h0001_0000, 5'd11, 32'd0, "mul_wrap");

    // Reset during iteration 10 of a multiply.
    set_op(3'b000, 32'd5, 32'd9, 32'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd12);
    repeat (11) step();
    rst = 1'b0;
    ex_if.MulE = 1'b0;
    step();
    check_val("rst_mid_alu", ex_if.ALU_ResultM, 32'd0);
    check_val("rst_mid_rd", {27'd0, ex_if.RD_M}, 32'd0);
    rst = 1'b1;
    #1 check_val("rst_mid_stall", {31'd0, ex_if.StallE}, 32'd0);
    set_op(3'b000, 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd13);
    step();
    check_val("post_rst_add", ex_if.ALU_ResultM, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
